// File: rtl/ml_cmd_dispatcher.sv
// Command front-end for ml_accelerator: decodes custom-opcode ML commands, queues them
// in order, issues one at a time and returns each result as a tagged writeback.
module ml_cmd_dispatcher #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter logic [6:0]  CUSTOM_OPCODE  = 7'b0001011,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_instruction,
  input  logic [31:0] cmd_rs1_data,
  input  logic [31:0] cmd_rs2_data,
  output logic        acc_start,
  output logic [1:0]  acc_op_mode,
  output logic [31:0] acc_instruction,
  output logic [31:0] acc_rs1_data,
  output logic [31:0] acc_rs2_data,
  output logic [4:0]  acc_rd_addr,
  output logic [4:0]  acc_rs1_addr,
  output logic [4:0]  acc_rs2_addr,
  input  logic        acc_ready,
  input  logic        acc_done,
  input  logic [31:0] acc_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_data,
  output logic        wb_error,
  output logic        busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   PTR_ONE      = {{AW{1'b0}}, 1'b1};

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [1:0]  op_mode;
  } cmd_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_t;

  function automatic cmd_entry_t decode_cmd(input logic [31:0] instr,
                                            input logic [31:0] rs1_data,
                                            input logic [31:0] rs2_data);
    cmd_entry_t e;
    e.instruction = instr;
    e.rs1_data    = rs1_data;
    e.rs2_data    = rs2_data;
    e.rd_addr     = instr[11:7];
    e.rs1_addr    = instr[19:15];
    e.rs2_addr    = instr[24:20];
    e.op_mode     = instr[13:12];
    return e;
  endfunction

  // funct3 values 100..111 have no accelerator mode
  function automatic logic is_illegal(input logic [31:0] instr);
    return (instr[6:0] != CUSTOM_OPCODE) || instr[14];
  endfunction

  cmd_entry_t      fifo_mem_r [FIFO_DEPTH];
  logic            fifo_ill_r [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_r, rd_ptr_r;
  logic            full_s, empty_s, push_s, pop_s;
  cmd_entry_t      head_s, cur_r;
  logic            head_ill_s;
  state_t          state_r, state_next_s;
  logic            start_s, done_s, timeout_s;
  logic [31:0]     result_r;
  logic            error_r;
  logic [CW-1:0]   tmo_cnt_r;

  assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  assign cmd_ready  = !full_s && !rst;
  assign push_s     = cmd_valid && cmd_ready;
  assign head_s     = fifo_mem_r[rd_ptr_r[AW-1:0]];
  assign head_ill_s = fifo_ill_r[rd_ptr_r[AW-1:0]];

  // Queue storage: decoded entry and illegal flag written at push
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r[AW-1:0]] <= decode_cmd(cmd_instruction, cmd_rs1_data, cmd_rs2_data);
      fifo_ill_r[wr_ptr_r[AW-1:0]] <= is_illegal(cmd_instruction);
    end
  end

  // Queue pointers with wrap bit
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_next_s;
  end

  // FSM next-state and per-cycle control strobes
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    start_s      = 1'b0;
    done_s       = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s        = 1'b1;
          state_next_s = head_ill_s ? ST_WRITEBACK : ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (acc_ready) begin
          start_s      = 1'b1;
          state_next_s = ST_WAIT_DONE;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_WAIT_DONE: begin
        if (acc_done) begin
          done_s       = 1'b1;
          state_next_s = ST_WRITEBACK;
        end else if (tmo_cnt_r == TIMEOUT_LAST) begin
          timeout_s    = 1'b1;
          state_next_s = ST_WRITEBACK;
        end else begin
          state_next_s = ST_WAIT_DONE;
        end
      end
      ST_WRITEBACK: begin
        if (wb_ready) state_next_s = ST_IDLE;
        else          state_next_s = ST_WRITEBACK;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Working registers: popped command, result/error and timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_r     <= '0;
      result_r  <= 32'd0;
      error_r   <= 1'b0;
      tmo_cnt_r <= '0;
    end else begin
      if (pop_s) begin
        cur_r    <= head_s;
        result_r <= 32'd0;
        error_r  <= head_ill_s;
      end else if (done_s) begin
        result_r <= acc_result;
        error_r  <= 1'b0;
      end else if (timeout_s) begin
        result_r <= 32'd0;
        error_r  <= 1'b1;
      end
      if (start_s)                      tmo_cnt_r <= '0;
      else if (state_r == ST_WAIT_DONE) tmo_cnt_r <= tmo_cnt_r + CW'(1);
    end
  end

  // acc_start must coincide with the acc_ready cycle, so it is the only Mealy output
  assign acc_start       = start_s && !rst;
  assign acc_op_mode     = cur_r.op_mode;
  assign acc_instruction = cur_r.instruction;
  assign acc_rs1_data    = cur_r.rs1_data;
  assign acc_rs2_data    = cur_r.rs2_data;
  assign acc_rd_addr     = cur_r.rd_addr;
  assign acc_rs1_addr    = cur_r.rs1_addr;
  assign acc_rs2_addr    = cur_r.rs2_addr;
  assign wb_valid        = (state_r == ST_WRITEBACK);
  assign wb_rd_addr      = cur_r.rd_addr;
  assign wb_data         = result_r;
  assign wb_error        = error_r;
  assign busy            = (state_r != ST_IDLE) || !empty_s;

endmodule

// File: tb/tb_ml_cmd_dispatcher.sv
// Directed self-checking bench for ml_cmd_dispatcher (TIMEOUT_CYCLES=16, FIFO_DEPTH=4).
module tb_ml_cmd_dispatcher;
  logic        clk = 1'b0;
  logic        rst, cmd_valid, cmd_ready, acc_start, acc_ready, acc_done;
  logic        wb_valid, wb_ready, wb_error, busy;
  logic [31:0] cmd_instruction, cmd_rs1_data, cmd_rs2_data;
  logic [31:0] acc_instruction, acc_rs1_data, acc_rs2_data, acc_result, wb_data;
  logic [1:0]  acc_op_mode;
  logic [4:0]  acc_rd_addr, acc_rs1_addr, acc_rs2_addr, wb_rd_addr;
  logic [154:0] all_outs;
  logic [38:0]  wb_bus;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ml_cmd_dispatcher #(.FIFO_DEPTH(4), .CUSTOM_OPCODE(7'b0001011), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_instruction(cmd_instruction), .cmd_rs1_data(cmd_rs1_data), .cmd_rs2_data(cmd_rs2_data),
    .acc_start(acc_start), .acc_op_mode(acc_op_mode), .acc_instruction(acc_instruction),
    .acc_rs1_data(acc_rs1_data), .acc_rs2_data(acc_rs2_data), .acc_rd_addr(acc_rd_addr),
    .acc_rs1_addr(acc_rs1_addr), .acc_rs2_addr(acc_rs2_addr), .acc_ready(acc_ready),
    .acc_done(acc_done), .acc_result(acc_result), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .wb_error(wb_error), .busy(busy)
  );

  assign all_outs = {cmd_ready, acc_start, acc_op_mode, acc_instruction, acc_rs1_data, acc_rs2_data,
                     acc_rd_addr, acc_rs1_addr, acc_rs2_addr, wb_valid, wb_rd_addr, wb_data,
                     wb_error, busy};
  assign wb_bus = {wb_valid, wb_error, wb_rd_addr, wb_data};

  function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2);
    return {7'd0, rs2, rs1, f3, rd, opc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2);
    cmd_valid       = 1'b1;
    cmd_instruction = ins;
    cmd_rs1_data    = d1;
    cmd_rs2_data    = d2;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_instruction = 32'd0; cmd_rs1_data = 32'd0;
    cmd_rs2_data = 32'd0; acc_ready = 1'b0; acc_done = 1'b0; acc_result = 32'd0; wb_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (all_outs !== 155'd0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", all_outs); end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL reset_release: got %b want 10", {cmd_ready, busy}); end
    step();
  endtask

  task automatic test_basic();
    acc_ready = 1'b1;
    drive_cmd(mk_instr(7'h0B, 3'd0, 5'd0, 5'd0, 5'd0), 32'h11, 32'h22);
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", cmd_ready); end
    step(); cmd_valid = 1'b0; #1;
    n_checks++;
    if ({acc_start, busy} !== 2'b01) begin n_fail++; $display("FAIL basic_n1: got %b want 01", {acc_start, busy}); end
    step(); #1;
    n_checks++;
    if ({acc_start, acc_op_mode, acc_instruction} !== {1'b1, 2'b00, 32'h0000000B}) begin
      n_fail++; $display("FAIL basic_start: got %b/%b/%h want 1/00/0000000b", acc_start, acc_op_mode, acc_instruction);
    end
    n_checks++;
    if ({acc_rs1_data, acc_rs2_data} !== {32'h11, 32'h22}) begin
      n_fail++; $display("FAIL basic_data: got %h %h want 11 22", acc_rs1_data, acc_rs2_data);
    end
    step(); acc_done = 1'b1; acc_result = 32'h12345678; #1;
    n_checks++;
    if (acc_start !== 1'b0) begin n_fail++; $display("FAIL basic_single_pulse: got %b want 0", acc_start); end
    step(); acc_done = 1'b0; wb_ready = 1'b1; #1;
    n_checks++;
    if (wb_bus !== {1'b1, 1'b0, 5'd0, 32'h12345678}) begin
      n_fail++; $display("FAIL basic_wb: got %h want %h", wb_bus, {1'b1, 1'b0, 5'd0, 32'h12345678});
    end
    step(); wb_ready = 1'b0; #1;
    n_checks++;
    if ({wb_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL basic_idle: got %b want 00", {wb_valid, busy}); end
  endtask

  task automatic test_fifo_full();
    acc_ready = 1'b0; wb_ready = 1'b0;
    drive_cmd(mk_instr(7'h33, 3'd0, 5'd31, 5'd0, 5'd0), 32'd0, 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive_cmd(mk_instr(7'h0B, 3'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3)), 32'h100 + 32'(i), 32'h200 + 32'(i));
      #1;
      n_checks++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL full_push%0d_ready: got %b want 1", i, cmd_ready); end
      step();
    end
    drive_cmd(mk_instr(7'h0B, 3'd0, 5'd20, 5'd0, 5'd0), 32'd0, 32'd0);
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", cmd_ready); end
    n_checks++;
    if (wb_bus !== {1'b1, 1'b1, 5'd31, 32'd0}) begin
      n_fail++; $display("FAIL full_illegal_wb: got %h want %h", wb_bus, {1'b1, 1'b1, 5'd31, 32'd0});
    end
    wb_ready = 1'b1;
    step(); cmd_valid = 1'b0; wb_ready = 1'b0; #1;
    n_checks++;
    if ({cmd_ready, wb_valid} !== 2'b00) begin n_fail++; $display("FAIL full_pop_cycle: got %b want 00", {cmd_ready, wb_valid}); end
    step(); #1;
    n_checks++;
    if ({cmd_ready, acc_start, acc_op_mode, acc_rd_addr} !== {1'b1, 1'b0, 2'd0, 5'd1}) begin
      n_fail++; $display("FAIL full_hold_issue: got %b want 1000001", {cmd_ready, acc_start, acc_op_mode, acc_rd_addr});
    end
    acc_ready = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      int c;
      c = 0;
      while (acc_start !== 1'b1 && c < 8) begin step(); #1; c++; end
      n_checks++;
      if ({acc_start, acc_op_mode, acc_rd_addr, acc_rs1_addr} !== {1'b1, 2'(i), 5'(i + 1), 5'(i + 2)}) begin
        n_fail++; $display("FAIL full_issue%0d: got start=%b mode=%0d rd=%0d rs1=%0d want 1 %0d %0d %0d",
                           i, acc_start, acc_op_mode, acc_rd_addr, acc_rs1_addr, i, i + 1, i + 2);
      end
      step(); acc_done = 1'b1; acc_result = 32'hA0 + 32'(i); #1;
      step(); acc_done = 1'b0; wb_ready = 1'b1; #1;
      n_checks++;
      if (wb_bus !== {1'b1, 1'b0, 5'(i + 1), 32'hA0 + 32'(i)}) begin
        n_fail++; $display("FAIL full_wb%0d: got %h want %h", i, wb_bus, {1'b1, 1'b0, 5'(i + 1), 32'hA0 + 32'(i)});
      end
      step(); wb_ready = 1'b0; #1;
    end
    repeat (4) step();
    #1;
    n_checks++;
    if ({wb_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL full_fifth_rejected: got %b want 00", {wb_valid, busy}); end
  endtask

  task automatic test_illegal_order();
    logic [4:0] exp_rd  [3] = '{5'd6, 5'd7, 5'd8};
    logic       exp_ill [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0] exp_md  [3] = '{2'd2, 2'd0, 2'd3};
    acc_ready = 1'b0; wb_ready = 1'b0;
    drive_cmd(mk_instr(7'h0B, 3'd2, 5'd6, 5'd1, 5'd2), 32'd1, 32'd2); step();
    drive_cmd(mk_instr(7'h33, 3'd0, 5'd7, 5'd1, 5'd2), 32'd3, 32'd4); step();
    drive_cmd(mk_instr(7'h0B, 3'd3, 5'd8, 5'd1, 5'd2), 32'd5, 32'd6); step();
    cmd_valid = 1'b0; acc_ready = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      int  started;
      logic got, pend;
      started = 0; got = 1'b0; pend = 1'b0;
      for (int c = 0; c < 12 && !got; c++) begin
        if (acc_start === 1'b1) begin
          started++;
          pend = 1'b1;
          n_checks++;
          if (acc_op_mode !== exp_md[k]) begin n_fail++; $display("FAIL illegal_mode%0d: got %0d want %0d", k, acc_op_mode, exp_md[k]); end
        end
        if (wb_valid === 1'b1) begin
          n_checks++;
          if (wb_bus !== {1'b1, exp_ill[k], exp_rd[k], exp_ill[k] ? 32'd0 : 32'h5000 + 32'(k)}) begin
            n_fail++; $display("FAIL illegal_wb%0d: got %h want %h", k, wb_bus,
                               {1'b1, exp_ill[k], exp_rd[k], exp_ill[k] ? 32'd0 : 32'h5000 + 32'(k)});
          end
          wb_ready = 1'b1;
          got = 1'b1;
        end
        step();
        acc_done = pend; acc_result = 32'h5000 + 32'(k); pend = 1'b0; wb_ready = 1'b0;
        #1;
      end
      n_checks++;
      if (!got || started != (exp_ill[k] ? 0 : 1)) begin
        n_fail++; $display("FAIL illegal_seq%0d: got wb=%b starts=%0d want wb=1 starts=%0d", k, got, started, exp_ill[k] ? 0 : 1);
      end
    end
  endtask

  task automatic test_timeout();
    logic early;
    acc_ready = 1'b0;
    drive_cmd(mk_instr(7'h0B, 3'd1, 5'd9, 5'd0, 5'd0), 32'd7, 32'd8); step();
    cmd_valid = 1'b0; step();
    acc_ready = 1'b1; #1;
    n_checks++;
    if ({acc_start, acc_op_mode} !== 3'b101) begin n_fail++; $display("FAIL timeout_start: got %b want 101", {acc_start, acc_op_mode}); end
    early = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step(); #1;
      if (wb_valid === 1'b1) early = 1'b1;
    end
    n_checks++;
    if (early !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got wb_valid before start+17 want none"); end
    step(); #1;
    n_checks++;
    if (wb_bus !== {1'b1, 1'b1, 5'd9, 32'd0}) begin
      n_fail++; $display("FAIL timeout_wb: got %h want %h", wb_bus, {1'b1, 1'b1, 5'd9, 32'd0});
    end
    acc_done = 1'b1; acc_result = 32'hDEAD_BEEF;
    step(); acc_done = 1'b0; #1;
    n_checks++;
    if (wb_bus !== {1'b1, 1'b1, 5'd9, 32'd0}) begin
      n_fail++; $display("FAIL timeout_late_done: got %h want %h", wb_bus, {1'b1, 1'b1, 5'd9, 32'd0});
    end
    wb_ready = 1'b1; step(); wb_ready = 1'b0; acc_done = 1'b1; step(); acc_done = 1'b0;
    repeat (2) step();
    #1;
    n_checks++;
    if ({wb_valid, busy, acc_start} !== 3'b000) begin
      n_fail++; $display("FAIL timeout_idle: got %b want 000", {wb_valid, busy, acc_start});
    end
  endtask

  task automatic test_wb_stall();
    acc_ready = 1'b0; wb_ready = 1'b0;
    drive_cmd(mk_instr(7'h0B, 3'd2, 5'd10, 5'd0, 5'd0), 32'd0, 32'd0); step();
    drive_cmd(mk_instr(7'h0B, 3'd3, 5'd11, 5'd0, 5'd0), 32'd0, 32'd0); step();
    cmd_valid = 1'b0; acc_ready = 1'b1; #1;
    n_checks++;
    if ({acc_start, acc_op_mode} !== 3'b110) begin n_fail++; $display("FAIL stall_start: got %b want 110", {acc_start, acc_op_mode}); end
    step(); acc_done = 1'b1; acc_result = 32'hCAFE_0001; #1;
    step(); acc_done = 1'b0; #1;
    for (int s = 0; s < 5; s++) begin
      n_checks++;
      if ({acc_start, wb_bus} !== {1'b0, 1'b1, 1'b0, 5'd10, 32'hCAFE_0001}) begin
        n_fail++; $display("FAIL stall_hold%0d: got %h want %h", s, {acc_start, wb_bus}, {1'b0, 1'b1, 1'b0, 5'd10, 32'hCAFE_0001});
      end
      step(); #1;
    end
    wb_ready = 1'b1;
    step(); wb_ready = 1'b0; #1;
    n_checks++;
    if ({acc_start, wb_valid} !== 2'b00) begin n_fail++; $display("FAIL stall_w1: got %b want 00", {acc_start, wb_valid}); end
    step(); #1;
    n_checks++;
    if ({acc_start, acc_op_mode, acc_rd_addr} !== {1'b1, 2'd3, 5'd11}) begin
      n_fail++; $display("FAIL stall_w2: got %b want %b", {acc_start, acc_op_mode, acc_rd_addr}, {1'b1, 2'd3, 5'd11});
    end
    step(); acc_done = 1'b1; acc_result = 32'hCAFE_0002; #1;
    step(); acc_done = 1'b0; wb_ready = 1'b1; #1;
    n_checks++;
    if (wb_bus !== {1'b1, 1'b0, 5'd11, 32'hCAFE_0002}) begin
      n_fail++; $display("FAIL stall_second_wb: got %h want %h", wb_bus, {1'b1, 1'b0, 5'd11, 32'hCAFE_0002});
    end
    step(); wb_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    logic seen;
    acc_ready = 1'b1; wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(mk_instr(7'h0B, 3'(i), 5'(i + 12), 5'd0, 5'd0), 32'd0, 32'd0);
      step();
    end
    cmd_valid = 1'b0; #1;
    n_checks++;
    if ({busy, acc_start, wb_valid} !== 3'b100) begin
      n_fail++; $display("FAIL midop_wait: got %b want 100", {busy, acc_start, wb_valid});
    end
    rst = 1'b1;
    step(); #1;
    n_checks++;
    if (all_outs !== 155'd0) begin n_fail++; $display("FAIL midop_reset_outs: got %h want 0", all_outs); end
    rst = 1'b0; acc_done = 1'b1; acc_result = 32'h0BAD_0BAD; wb_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(); acc_done = 1'b0; #1;
      if (acc_start === 1'b1 || wb_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midop_abandon: got activity after reset want none"); end
    wb_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_fifo_full();
    test_illegal_order();
    test_timeout();
    test_wb_stall();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ml_cmd_dispatcher.md
# ml_cmd_dispatcher

Command front-end sitting directly upstream of `ml_accelerator`. Accepts custom-opcode instructions and operands from the softcore, decodes them into accelerator `op_mode`, and buffers them in a small in-order FIFO. Issues them one at a time with a single-cycle `start` pulse and waits for `done`. Returns each result to the core through a valid/ready writeback port, tagged with the destination register.

## Interface
- `FIFO_DEPTH`, 4: command queue entries (power of two, ≥2)
- `CUSTOM_OPCODE`, 7'b0001011: instruction[6:0] value accepted as an ML command
- `TIMEOUT_CYCLES`, 1024: max cycles in WAIT_DONE before an error writeback
- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  core presents a command
- `cmd_ready`  out  1  queue can accept (= !full, 0 while `rst`)
- `cmd_instruction`  in  32  raw instruction word
- `cmd_rs1_data`, `cmd_rs2_data`  in  32 each  operand values
- `acc_start`  out  1  one-cycle start pulse to accelerator
- `acc_op_mode`  out  2  00 CONV2D, 01 DEPTHWISE_CONV2D, 10 MATRIX_ADD, 11 FULLY_CONNECTED
- `acc_instruction`, `acc_rs1_data`, `acc_rs2_data`  out  32 each  forwarded command fields
- `acc_rd_addr`, `acc_rs1_addr`, `acc_rs2_addr`  out  5 each  decoded register indices
- `acc_ready`  in  1  accelerator idle, may be started
- `acc_done`  in  1  accelerator completion strobe
- `acc_result`  in  32  accelerator result, valid with `acc_done`
- `wb_valid`  out  1  writeback available
- `wb_ready`  in  1  core accepts writeback
- `wb_rd_addr`  out  5  destination register
- `wb_data`  out  32  result (0 on error)
- `wb_error`  out  1  illegal command or timeout
- `busy`  out  1  FSM not IDLE or FIFO non-empty

## Operation
- Push when `cmd_valid && cmd_ready`. Decode at push:
  - rd=[11:7], rs1=[19:15], rs2=[24:20], funct3=[14:12].
  - funct3 000/001/010/011 → op_mode 00/01/10/11.
  - Illegal if opcode ≠ `CUSTOM_OPCODE` or funct3 ≥ 100. Illegal entries are still queued, flagged, so writeback order equals command order.
- Entry contents: instruction, rs1/rs2 data, rd/rs1/rs2 addr, op_mode, illegal flag.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into working registers. Illegal entry → WRITEBACK with error. Legal entry → ISSUE.
  - ISSUE: wait for `acc_ready`. In the cycle `acc_ready`=1, assert `acc_start` for exactly that cycle, clear the timeout counter, then → WAIT_DONE.
  - WAIT_DONE: on `acc_done`, capture `acc_result`, set error=0, then → WRITEBACK. If the counter reaches `TIMEOUT_CYCLES-1` without `acc_done`, set data=0, error=1, then → WRITEBACK.
  - WRITEBACK: hold `wb_valid`=1 with stable `wb_rd_addr`/`wb_data`/`wb_error` until `wb_ready`; then → IDLE.
- `acc_*` data outputs come from the working registers and stay stable from ISSUE entry until WRITEBACK exit.
- `acc_done` outside WAIT_DONE is ignored.
- rd=0 commands are executed and written back normally; the core discards them.
- FIFO: circular read/write pointers with extra wrap bit. full = same index, different wrap bit. empty = pointers equal.
  - Push and pop in the same cycle are allowed when not full.
  - When full, `cmd_ready`=0 even if a pop occurs that cycle.

## Timing
- Reset (`rst`=1 at a clock edge): FIFO emptied, FSM → IDLE, timeout counter cleared. All outputs 0, including `cmd_ready`, `acc_start`, `wb_valid`, `busy`, and every data output.
- Reset mid-operation abandons the in-flight command and all queued commands. No writeback is produced for them.
- Latency (cycle N = push into an empty FIFO with FSM in IDLE):
  - Pop at N+1.
  - ISSUE at N+2; `acc_start` at N+2 if `acc_ready`=1.
  - `acc_done` at cycle D → `wb_valid` at D+1.
  - Illegal command: `wb_valid` at N+2.
- Back-to-back: after a writeback handshake at cycle W, IDLE at W+1, next `acc_start` no earlier than W+2.
- Only one command is outstanding in the accelerator at a time.

## Test plan
- Reset, then push instruction 0x0000000B (funct3 000, rd=0) with `acc_ready`=1 → `acc_start` one cycle, `acc_op_mode`=00, exactly 2 cycles after push. Then `acc_done` with result 0x12345678 → `wb_valid`, `wb_data`=0x12345678, `wb_error`=0 one cycle later.
- Push four commands with funct3 000/001/010/011 and rd 1..4 while `acc_ready`=0 → `cmd_ready`=0 after the 4th push; a 5th push is not accepted. Raise `acc_ready` → starts issue in op_mode order 00,01,10,11 with writebacks for rd 1,2,3,4 in order.
- Push an opcode 0x33 instruction between two legal ones → no `acc_start` for it; its writeback has `wb_error`=1, `wb_data`=0, and arrives in order.
- Hold `acc_done`=0 after start with `TIMEOUT_CYCLES`=16 → `wb_valid` with `wb_error`=1 on cycle start+17. A late `acc_done` afterwards is ignored.
- Hold `wb_ready`=0 for 5 cycles in WRITEBACK → `wb_*` stable and no new `acc_start` until after the handshake.
- Assert `rst` during WAIT_DONE with 2 entries queued → next cycle all outputs 0 and `busy`=0; no writeback for those commands.
